// File: rtl/matrix_add_seq.sv
// matrix_add_seq: sequenced element-wise matrix add / subtract / accumulate.
// One matrix row per clock through W shared lane adders; the result is held in
// the CO register bank. Operands and opcode are captured when a command starts,
// so AI/BI may change freely while the command runs.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; clr zeroes the result bank
//   RUN    | writing row r_q+1 of CO each cycle; last row raises done
//
// A start seen on the last RUN cycle chains straight into a new command. This
// gives one matrix per H cycles. busy drops for that one cycle so that busy and
// done never overlap.

module matrix_add_seq #(
  parameter int bitlength = 8,
  parameter int H         = 3,
  parameter int W         = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic                      clr,
  input  logic [H*W*bitlength-1:0]  AI,
  input  logic [H*W*bitlength-1:0]  BI,
  output logic [H*W*bitlength-1:0]  CO,
  output logic                      busy,
  output logic                      done
);

  localparam int N   = H * W * bitlength;
  localparam int RWB = W * bitlength;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(H - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [1:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    co_q, co_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [RWB-1:0]  a_row, b_row, c_row, new_row;

  // Select the operand and old-result row addressed by the row counter.
  always_comb begin
    a_row = '0;
    b_row = '0;
    c_row = '0;
    for (int i = 0; i < H; i++) begin
      if (r_q == RW'(i)) begin
        a_row = a_q[i*RWB +: RWB];
        b_row = b_q[i*RWB +: RWB];
        c_row = co_q[i*RWB +: RWB];
      end
    end
  end

  // W shared lane adders; results wrap modulo 2^bitlength. Opcode 11 acts as add.
  always_comb begin
    new_row = '0;
    for (int j = 0; j < W; j++) begin
      case (op_q)
        OP_SUB:  new_row[j*bitlength +: bitlength] =
                   a_row[j*bitlength +: bitlength] - b_row[j*bitlength +: bitlength];
        OP_ACC:  new_row[j*bitlength +: bitlength] =
                   c_row[j*bitlength +: bitlength] + a_row[j*bitlength +: bitlength];
        default: new_row[j*bitlength +: bitlength] =
                   a_row[j*bitlength +: bitlength] + b_row[j*bitlength +: bitlength];
      endcase
    end
  end

  // Next-state logic: command acceptance, row write-back and completion.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = AI;
          b_d     = BI;
          op_d    = op;
          r_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (clr) begin
          co_d = '0;
        end
      end

      S_RUN: begin
        for (int i = 0; i < H; i++) begin
          if (r_q == RW'(i)) begin
            co_d[i*RWB +: RWB] = new_row;
          end
        end
        if (r_q == LAST_ROW) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          r_d    = '0;
          if (start) begin
            a_d     = AI;
            b_d     = BI;
            op_d    = op;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          r_d    = r_q + 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        r_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      co_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CO   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_matrix_add_seq.sv
// Directed bench for matrix_add_seq (H=3, W=4, 8-bit elements).
module tb_matrix_add_seq;

  localparam int BL = 8;
  localparam int H  = 3;
  localparam int W  = 4;
  localparam int N  = H * W * BL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         clr;
  logic [N-1:0] AI, BI;
  logic [N-1:0] CO;
  logic         busy, done;

  int vectors    = 0;
  int miscompares = 0;

  matrix_add_seq #(.bitlength(BL), .H(H), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .clr   (clr),
    .AI    (AI),
    .BI    (BI),
    .CO    (CO),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fill(input logic [7:0] v);
    logic [N-1:0] m;
    for (int k = 0; k < H * W; k++) m[k*BL +: BL] = v;
    return m;
  endfunction

  function automatic logic [N-1:0] put(input logic [N-1:0] m, input int i, input int j,
                                       input logic [7:0] v);
    logic [N-1:0] r;
    r = m;
    r[((i-1)*W + (j-1))*BL +: BL] = v;
    return r;
  endfunction

  function automatic logic [N-1:0] put_row(input logic [N-1:0] m, input int i,
                                           input logic [7:0] v);
    logic [N-1:0] r;
    r = m;
    for (int j = 1; j <= W; j++) r = put(r, i, j, v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive a start strobe that is sampled at the next edge (edge k).
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    op = o; AI = a; BI = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges after edge k until done is seen; bounded.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk(tag, N'(n), N'(exp_cycles));
  endtask

  logic [N-1:0] exp_m;
  int busy_cnt;
  int extra_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; clr = 1'b0; AI = '0; BI = '0;
    #12;
    chk("reset_co",   CO,   '0);
    chk("reset_busy", N'(busy), '0);
    chk("reset_done", N'(done), '0);
    step();
    rst_n = 1'b1;
    step();

    // Basic add: 3 + 5 = 8, row-by-row timing
    issue(2'b00, fill(8'd3), fill(8'd5));
    chk("add_busy_k", N'(busy), N'(1));
    chk("add_done_k", N'(done), '0);
    chk("add_co_k",   CO, '0);
    busy_cnt = 1;
    step();
    chk("add_row1", CO, put_row('0, 1, 8'd8));
    if (busy) busy_cnt++;
    step();
    chk("add_row2", CO, put_row(put_row('0, 1, 8'd8), 2, 8'd8));
    if (busy) busy_cnt++;
    step();
    chk("add_done_k3", N'(done), N'(1));
    chk("add_busy_k3", N'(busy), '0);
    chk("add_co_all8", CO, fill(8'd8));
    chk("add_busy_cycles", N'(busy_cnt), N'(3));
    step();
    chk("add_done_fall", N'(done), '0);

    // Wrap-around add and borrow
    issue(2'b00, put('0, 1, 1, 8'hF0), put('0, 1, 1, 8'h20));
    wait_done("wrap_add_lat", 3);
    chk("wrap_add", CO, put('0, 1, 1, 8'h10));
    step();
    issue(2'b01, put('0, 2, 3, 8'h01), put('0, 2, 3, 8'h02));
    wait_done("wrap_sub_lat", 3);
    chk("wrap_sub", CO, put('0, 2, 3, 8'hFF));
    step();

    // Opcode 11 behaves like add
    issue(2'b11, fill(8'd10), fill(8'd4));
    wait_done("op11_lat", 3);
    chk("op11_add", CO, fill(8'd14));
    step();

    // clr in IDLE, then three accumulates; clr while busy is ignored
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_idle", CO, '0);
    chk("clr_no_busy", N'(busy), '0);
    issue(2'b10, fill(8'd7), fill(8'hAA));
    wait_done("acc1_lat", 3);
    chk("acc1", CO, fill(8'd7));
    step();
    issue(2'b10, fill(8'd7), fill(8'hAA));
    clr = 1'b1;
    step();
    clr = 1'b0;
    wait_done("acc2_lat", 2);
    chk("acc2_clr_busy", CO, fill(8'd14));
    step();
    issue(2'b10, fill(8'd7), fill(8'h55));
    wait_done("acc3_lat", 3);
    chk("acc3", CO, fill(8'd21));
    step();

    // Operand isolation and start while busy
    issue(2'b00, fill(8'd1), fill(8'd2));
    AI = {$urandom, $urandom, $urandom}; BI = {$urandom, $urandom, $urandom};
    start = 1'b1;
    step();
    start = 1'b0;
    AI = {$urandom, $urandom, $urandom}; BI = {$urandom, $urandom, $urandom};
    step();
    AI = {$urandom, $urandom, $urandom}; BI = {$urandom, $urandom, $urandom};
    wait_done("iso_lat", 1);
    chk("iso_result", CO, fill(8'd3));
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done) extra_done++;
    end
    chk("iso_no_extra_done", N'(extra_done), '0);

    // Reset during the second RUN cycle
    issue(2'b00, fill(8'd9), fill(8'd9));
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_co",   CO, '0);
    chk("rst_mid_busy", N'(busy), '0);
    chk("rst_mid_done", N'(done), '0);
    #4;
    rst_n = 1'b1;
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done || busy) extra_done++;
    end
    chk("rst_no_done", N'(extra_done), '0);
    issue(2'b00, fill(8'd2), fill(8'd3));
    wait_done("post_rst_lat", 3);
    chk("post_rst", CO, fill(8'd5));
    step();

    // Back-to-back: start on the edge that raises done
    issue(2'b00, fill(8'd1), fill(8'd1));
    step();
    step();
    op = 2'b01; AI = fill(8'd9); BI = fill(8'd4); start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_done1", N'(done), N'(1));
    chk("b2b_co1", CO, fill(8'd2));
    step();
    chk("b2b_done_gap", N'(done), '0);
    chk("b2b_busy2", N'(busy), N'(1));
    wait_done("b2b_spacing", 2);
    chk("b2b_co2", CO, fill(8'd5));
    step();
    chk("b2b_idle", N'(busy | done), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
